// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the
// pipeline MEM stage (port 0) and the loader/debug port (port 1).
module dmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_stall,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WW = 4;
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_q, wait_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_port_q, resp_port_d;
  logic          p1_win;
  logic          rd_gnt;

  // Fixed priority to port 0 unless port 1 has waited MAX_WAIT cycles
  always_comb begin
    p1_win   = p1_req & (~p0_req | (wait_q == WMAX));
    p1_gnt   = rst_n & p1_win;
    p0_gnt   = rst_n & p0_req & ~p1_win;
    p0_stall = p0_req & ~p0_gnt;
  end

  // Steer the granted port onto the memory, idle bus otherwise
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      p0_gnt: begin
        mem_en    = 1'b1;
        mem_we    = p0_we;
        mem_addr  = p0_addr;
        mem_wdata = p0_wdata;
      end
      p1_gnt: begin
        mem_en    = 1'b1;
        mem_we    = p1_we;
        mem_addr  = p1_addr;
        mem_wdata = p1_wdata;
      end
      default: ;
    endcase
  end

  // Next state: saturating starvation count and read tag
  always_comb begin
    wait_d = '0;
    if (p1_req & ~p1_gnt) begin
      if (wait_q != WMAX) wait_d = wait_q + WW'(1);
      else                wait_d = wait_q;
    end
    rd_gnt       = (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);
    resp_valid_d = rd_gnt;
    resp_port_d  = rd_gnt ? p1_gnt : resp_port_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
    end else begin
      wait_q       <= wait_d;
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
    end
  end

  // Route read data to the issuing port; drop in-flight data in reset
  always_comb begin
    p0_rvalid = rst_n & resp_valid_q & ~resp_port_q;
    p1_rvalid = rst_n & resp_valid_q & resp_port_q;
    p0_rdata  = p0_rvalid ? mem_rdata : '0;
    p1_rdata  = p1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus read scoreboard for dmem_arbiter.
// A small RAM model stands in for the data memory array.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_stall, p0_rvalid, p1_gnt, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_stall(p0_stall),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [15:0] ram [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        rst_n;
    logic        r0, w0;
    logic [15:0] a0, d0;
    logic        r1, w1;
    logic [15:0] a1, d1;
    logic        g0, g1;
  } vec_t;

  typedef struct {
    logic        v;
    logic        p;
    logic [15:0] d;
  } rsp_t;

  vec_t        vt[$];
  rsp_t        sb[$];
  logic [15:0] ref_mem [256];

  function automatic vec_t mkv(
    logic rn,
    logic r0, logic w0, logic [15:0] a0, logic [15:0] d0,
    logic r1, logic w1, logic [15:0] a1, logic [15:0] d1,
    logic g0, logic g1);
    vec_t v;
    v.rst_n = rn;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string n, input logic [15:0] act,
                     input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    rsp_t        e;
    logic        ev;
    logic        xwe;
    logic [15:0] xa, xd;
    @(negedge clk);
    rst_n = v.rst_n;
    p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
    #2;
    chk("p0_gnt", 16'(p0_gnt), 16'(v.g0));
    chk("p1_gnt", 16'(p1_gnt), 16'(v.g1));
    chk("one_gnt", 16'(p0_gnt & p1_gnt), 16'h0);
    chk("p0_stall", 16'(p0_stall), 16'(v.r0 & ~v.g0));
    xwe = v.g0 ? v.w0 : (v.g1 ? v.w1 : 1'b0);
    xa  = v.g0 ? v.a0 : (v.g1 ? v.a1 : 16'h0);
    xd  = v.g0 ? v.d0 : (v.g1 ? v.d1 : 16'h0);
    chk("mem_en", 16'(mem_en), 16'(v.g0 | v.g1));
    chk("mem_we", 16'(mem_we), 16'(xwe));
    chk("mem_addr", mem_addr, xa);
    chk("mem_wdata", mem_wdata, xd);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{v: 1'b0, p: 1'b0, d: 16'h0};
    ev = e.v & v.rst_n;
    chk("p0_rvalid", 16'(p0_rvalid), 16'(ev & ~e.p));
    chk("p1_rvalid", 16'(p1_rvalid), 16'(ev & e.p));
    chk("p0_rdata", p0_rdata, (ev & ~e.p) ? e.d : 16'h0);
    chk("p1_rdata", p1_rdata, (ev & e.p) ? e.d : 16'h0);
    e.v = (v.g0 & ~v.w0) | (v.g1 & ~v.w1);
    e.p = v.g1;
    e.d = ref_mem[xa[7:0]];
    sb.push_back(e);
    if ((v.g0 | v.g1) && xwe) ref_mem[xa[7:0]] = xd;
  endtask

  localparam vec_t IDLE = '{rst_n: 1'b1, r0: 1'b0, w0: 1'b0,
    a0: 16'h0, d0: 16'h0, r1: 1'b0, w1: 1'b0, a1: 16'h0,
    d1: 16'h0, g0: 1'b0, g1: 1'b0};

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    mem_rdata = 16'h0;
    rst_n = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 16'h0; p0_wdata = 16'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 16'h0; p1_wdata = 16'h0;

    // reset with both requesting, then first contended cycle
    for (int i = 0; i < 3; i++)
      vt.push_back(mkv(0, 1,0,16'h30,0, 1,0,16'h40,0, 0,0));
    vt.push_back(mkv(1, 1,0,16'h30,0, 1,0,16'h40,0, 1,0));
    vt.push_back(IDLE);
    // port 0 write then read
    vt.push_back(mkv(1, 1,1,16'h0004,16'hABCD, 0,0,0,0, 1,0));
    vt.push_back(mkv(1, 1,0,16'h0004,0, 0,0,0,0, 1,0));
    vt.push_back(IDLE);
    // port 1 alone write then read
    vt.push_back(mkv(1, 0,0,0,0, 1,1,16'h0010,16'h1234, 0,1));
    vt.push_back(mkv(1, 0,0,0,0, 1,0,16'h0010,0, 0,1));
    vt.push_back(IDLE);
    // continuous contention, period 5
    for (int i = 0; i < 15; i++) begin
      if (i % 5 == 4)
        vt.push_back(mkv(1, 1,0,16'h4,0, 1,0,16'h10,0, 0,1));
      else
        vt.push_back(mkv(1, 1,0,16'h4,0, 1,0,16'h10,0, 1,0));
    end
    vt.push_back(IDLE);
    // cross traffic on 0x0020
    vt.push_back(mkv(1, 1,1,16'h20,16'h7777, 0,0,0,0, 1,0));
    vt.push_back(mkv(1, 1,0,16'h20,0, 1,1,16'h20,16'h5555, 1,0));
    vt.push_back(mkv(1, 0,0,0,0, 1,1,16'h20,16'h5555, 0,1));
    vt.push_back(mkv(1, 1,0,16'h20,0, 0,0,0,0, 1,0));
    vt.push_back(IDLE);

    foreach (vt[i]) step(vt[i]);

    // reset right after a port 1 read grant drops the response
    step(mkv(1, 0,0,0,0, 1,0,16'h10,0, 0,1));
    step(mkv(0, 0,0,0,0, 0,0,0,0, 0,0));
    step(IDLE);
    // build up starvation, reset, then confirm count restarts at 0
    for (int i = 0; i < 3; i++)
      step(mkv(1, 1,0,16'h4,0, 1,0,16'h10,0, 1,0));
    step(mkv(0, 1,0,16'h4,0, 1,0,16'h10,0, 0,0));
    for (int i = 0; i < 4; i++)
      step(mkv(1, 1,0,16'h4,0, 1,0,16'h10,0, 1,0));
    step(mkv(1, 1,0,16'h4,0, 1,0,16'h10,0, 0,1));
    step(IDLE);
    step(IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
